// File: rtl/mig_req_tx.sv
// mig_req_tx: serializes D-cache line requests into async-FIFO packet words.
// Optional header parity bit when MIG_REQ_TX_PARITY_EN is defined.
module mig_req_tx #(
    parameter int AFIFODW = 32,
    parameter int LINEW   = 128,
    parameter int ADRW    = 28
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [ADRW-1:0]    req_adr,
    input  logic [LINEW-1:0]   req_wdata,
    output logic               fifo_wen,
    output logic [AFIFODW-1:0] fifo_wdata,
    input  logic               fifo_wqfull,
    output logic               busy
);

    localparam int NBEAT = LINEW / AFIFODW;
    localparam int CNTW  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(NBEAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                          state_q;
    logic [CNTW-1:0]                 cnt_q;
    logic                            wr_q;
    logic [ADRW-1:0]                 adr_q;
    logic [NBEAT-1:0][AFIFODW-1:0]   wdata_q;
    logic                            par;
    logic [AFIFODW-1:0]              hdr;

`ifdef MIG_REQ_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            par_q <= 1'b0;
        end else if (state_q == IDLE && req_valid) begin
            par_q <= req_wr & (^req_wdata);
        end
    end

    assign par = par_q;
`else
    assign par = 1'b0;
`endif

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_wr;
                        adr_q   <= req_adr;
                        wdata_q <= req_wdata;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (!fifo_wqfull) begin
                        cnt_q   <= '0;
                        state_q <= wr_q ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (!fifo_wqfull) begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        hdr              = '0;
        hdr[AFIFODW-1]   = wr_q;
        hdr[AFIFODW-2]   = par;
        hdr[ADRW-1:0]    = adr_q;
    end

    always_comb begin
        fifo_wdata = '0;
        unique case (state_q)
            HDR:     fifo_wdata = hdr;
            DATA:    fifo_wdata = wdata_q[cnt_q];
            default: fifo_wdata = '0;
        endcase
    end

    assign fifo_wen  = (state_q == HDR || state_q == DATA) && !fifo_wqfull;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mig_req_tx.sv
// Scoreboard bench for mig_req_tx: randomized requests and FIFO-full pressure
// checked against a packet-level reference model.
module tb_mig_req_tx;

    localparam int DW    = 32;
    localparam int LW    = 128;
    localparam int AW    = 28;
    localparam int NBEAT = LW / DW;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_adr = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          fifo_wen;
    logic [DW-1:0] fifo_wdata;
    logic          fifo_wqfull = 1'b0;
    logic          busy;

    int tests = 0;
    int errors = 0;
    int pushes = 0;
    bit rand_full = 0;
    logic [DW-1:0] expq[$];

    mig_req_tx #(.AFIFODW(DW), .LINEW(LW), .ADRW(AW)) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wr(req_wr),
        .req_adr(req_adr),
        .req_wdata(req_wdata),
        .fifo_wen(fifo_wen),
        .fifo_wdata(fifo_wdata),
        .fifo_wqfull(fifo_wqfull),
        .busy(busy)
    );

    always #5 wclk = ~wclk;

    // Reference model: a request becomes a header word plus, for writes,
    // the line split LSB-first into DW-wide beats.
    task automatic model_push(input bit wr, input logic [AW-1:0] adr,
                              input logic [LW-1:0] d);
        logic [DW-1:0] h;
        bit par;
        par = 1'b0;
`ifdef MIG_REQ_TX_PARITY_EN
        if (wr) par = ^d;
`endif
        h = 32'(adr);
        if (wr)  h = h | 32'h8000_0000;
        if (par) h = h | 32'h4000_0000;
        expq.push_back(h);
        if (wr) begin
            for (int k = 0; k < NBEAT; k++) begin
                expq.push_back(DW'(d >> (k * DW)));
            end
        end
    endtask

    always @(negedge wclk) begin
        tests++;
        if (!busy) begin
            if (fifo_wen !== 1'b0 || fifo_wdata !== '0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle: wen=%b wdata=%h ready=%b, want 0 0 1",
                         fifo_wen, fifo_wdata, req_ready);
            end
        end else if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_busy: wen=%b wdata=%h, want no packet",
                     fifo_wen, fifo_wdata);
        end else begin
            if (fifo_wdata !== expq[0] || fifo_wen !== !fifo_wqfull) begin
                errors++;
                $display("FAIL word: wdata=%h wen=%b full=%b, want %h wen=%b",
                         fifo_wdata, fifo_wen, fifo_wqfull, expq[0], !fifo_wqfull);
            end
            if (fifo_wen === 1'b1) begin
                void'(expq.pop_front());
                pushes++;
            end
        end
    end

    always @(posedge wclk) begin
        if (rand_full) begin
            #1 fifo_wqfull = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Returns #1 after the accepting edge.
    task automatic send(input bit wr, input logic [AW-1:0] adr,
                        input logic [LW-1:0] d);
        int n;
        n = 0;
        @(negedge wclk);
        while (req_ready !== 1'b1 && n < 500) begin
            @(negedge wclk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            tests++;
            errors++;
            $display("FAIL handshake_timeout: ready=%b, want 1", req_ready);
            return;
        end
        req_valid = 1'b1;
        req_wr    = wr;
        req_adr   = adr;
        req_wdata = d;
        model_push(wr, adr, d);
        @(posedge wclk);
        #1;
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_adr   = AW'($urandom);
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 2000) begin
            @(negedge wclk);
            n++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        int p0;
        logic [LW-1:0] pat;

        // Reset behaviour and quiet idle
        repeat (3) @(negedge wclk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_wen", 64'(fifo_wen), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge wclk);
        #1 wrst_n = 1'b1;
        p0 = pushes;
        repeat (20) @(negedge wclk);
        check("idle_no_push", 64'(pushes - p0), 64'd0);

        // Read: header alone, one cycle after handshake
        send(1'b0, 28'h0123456, '0);
        @(negedge wclk);
        check("rd_hdr", 64'(fifo_wdata), 64'h0012_3456);
        check("rd_wen", 64'(fifo_wen), 64'd1);
        @(negedge wclk);
        check("rd_done", 64'(busy), 64'd0);

        // Write: 5 consecutive pushes then idle
        pat = 128'h77776666_55554444_33332222_11110000;
        send(1'b1, 28'h10, pat);
        @(negedge wclk);
        check("wr_hdr", 64'(fifo_wdata), 64'h8000_0010);
        for (int i = 0; i < NBEAT; i++) begin
            @(negedge wclk);
            check("wr_beat_wen", 64'(fifo_wen), 64'd1);
        end
        @(negedge wclk);
        check("wr_busy_fall", 64'(busy), 64'd0);

        // Full for 3 cycles while beat 2 is presented
        p0 = pushes;
        send(1'b1, 28'hABCDEF, {$urandom, $urandom, $urandom, $urandom});
        repeat (3) @(posedge wclk);
        #1 fifo_wqfull = 1'b1;
        repeat (3) begin
            @(negedge wclk);
            check("full_wen", 64'(fifo_wen), 64'd0);
        end
        @(posedge wclk);
        #1 fifo_wqfull = 1'b0;
        drain();
        check("full_count", 64'(pushes - p0), 64'd5);

        // Reset mid-packet during beat 1
        send(1'b1, 28'h55, {$urandom, $urandom, $urandom, $urandom});
        repeat (2) @(posedge wclk);
        #1 wrst_n = 1'b0;
        expq.delete();
        #1;
        check("rst_mid_wen", 64'(fifo_wen), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        @(posedge wclk);
        #1 wrst_n = 1'b1;
        send(1'b0, 28'h777, '0);
        @(negedge wclk);
        check("post_rst_hdr", 64'(fifo_wdata), 64'h0000_0777);

        // Parity header bit
        drain();
        send(1'b1, 28'h20, 128'h1);
        @(negedge wclk);
`ifdef MIG_REQ_TX_PARITY_EN
        check("par_hdr", 64'(fifo_wdata), 64'hC000_0020);
`else
        check("par_hdr", 64'(fifo_wdata), 64'h8000_0020);
`endif
        drain();

        // Randomized traffic under random back-pressure
        rand_full = 1;
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom), AW'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 3)) @(negedge wclk);
        end
        rand_full = 0;
        @(posedge wclk);
        #1 fifo_wqfull = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
